// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-setting controller for the HH:MM:SS clock
//
// Freezes the counter chain, edits hour/minute/second one field at a time,
// and commits the result with a single-cycle load strobe.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick       1 Hz pulse from the clock divider
//   btn_mode   debounced pulse: advance to the next edit field / commit
//   btn_inc    debounced pulse: increment the selected field
//   cur_time   live {hour, minute, second}, 8-bit binary each
//   run_en     counter enable
//   load       one-cycle commit strobe
//   load_time  {hour, minute, second} to load, valid while load=1
//   blank_mask display blanking {hour, min, sec}, 1 = blank
//   edit_mode  high in any set state
module clock_set_ctrl #(
    parameter int HOUR    = 5,
    parameter int MINUTE  = 3,
    parameter int SECOND  = 21,
    parameter int TIMEOUT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] cur_time,
    output logic        run_en,
    output logic        load,
    output logic [23:0] load_time,
    output logic [2:0]  blank_mask,
    output logic        edit_mode
);

    localparam int IW = $clog2(TIMEOUT + 1);

    // Moduli as 9-bit values so a modulus of 256 still compares correctly.
    localparam logic [8:0] HOUR_MOD   = 9'(HOUR);
    localparam logic [8:0] MINUTE_MOD = 9'(MINUTE);
    localparam logic [8:0] SECOND_MOD = 9'(SECOND);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    edit_h, edit_m, edit_s;
    logic [7:0]    edit_h_nx, edit_m_nx, edit_s_nx;
    logic [IW-1:0] idle_cnt, idle_nx;
    logic          blink_phase, blink_nx;
    logic          commit;
    logic          run_en_nx, load_nx, edit_mode_nx;
    logic [23:0]   load_time_nx;
    logic [2:0]    blank_nx;

    // Captured values outside the field range are forced to 0.
    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [8:0] m);
        return ({1'b0, v} >= m) ? 8'd0 : v;
    endfunction

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [8:0] m);
        return ({1'b0, v} >= (m - 9'd1)) ? 8'd0 : v + 8'd1;
    endfunction

    always_comb begin
        state_nx     = state;
        edit_h_nx    = edit_h;
        edit_m_nx    = edit_m;
        edit_s_nx    = edit_s;
        idle_nx      = idle_cnt;
        blink_nx     = blink_phase;
        commit       = 1'b0;
        load_nx      = 1'b0;
        load_time_nx = load_time;

        case (state)
            RUN: begin
                if (btn_mode) begin
                    state_nx  = SET_H;
                    edit_h_nx = sanitize(cur_time[23:16], HOUR_MOD);
                    edit_m_nx = sanitize(cur_time[15:8], MINUTE_MOD);
                    edit_s_nx = sanitize(cur_time[7:0], SECOND_MOD);
                    idle_nx   = '0;
                    blink_nx  = 1'b1;
                end
            end
            default: begin
                if (btn_mode) begin
                    // btn_mode wins over a simultaneous btn_inc.
                    idle_nx  = '0;
                    blink_nx = 1'b1;
                    case (state)
                        SET_H:   state_nx = SET_M;
                        SET_M:   state_nx = SET_S;
                        default: begin
                            state_nx     = RUN;
                            commit       = 1'b1;
                            load_nx      = 1'b1;
                            load_time_nx = {edit_h, edit_m, edit_s};
                        end
                    endcase
                end else if (btn_inc) begin
                    // A button pulse outranks an expiring tick.
                    idle_nx = '0;
                    if (tick) begin
                        blink_nx = ~blink_phase;
                    end
                    case (state)
                        SET_H:   edit_h_nx = wrap_inc(edit_h, HOUR_MOD);
                        SET_M:   edit_m_nx = wrap_inc(edit_m, MINUTE_MOD);
                        default: edit_s_nx = wrap_inc(edit_s, SECOND_MOD);
                    endcase
                end else if (tick) begin
                    blink_nx = ~blink_phase;
                    if (idle_cnt == IDLE_LAST) begin
                        state_nx = RUN;
                        idle_nx  = '0;
                    end else begin
                        idle_nx = idle_cnt + IDLE_ONE;
                    end
                end
            end
        endcase

        // Counters stay frozen for the load cycle of a commit.
        run_en_nx    = (state_nx == RUN) && !commit;
        edit_mode_nx = (state_nx != RUN);
        blank_nx     = 3'b000;
        if (state_nx != RUN && !blink_nx) begin
            case (state_nx)
                SET_H:   blank_nx = 3'b100;
                SET_M:   blank_nx = 3'b010;
                default: blank_nx = 3'b001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            edit_h      <= 8'd0;
            edit_m      <= 8'd0;
            edit_s      <= 8'd0;
            idle_cnt    <= '0;
            blink_phase <= 1'b0;
            run_en      <= 1'b1;
            load        <= 1'b0;
            load_time   <= 24'd0;
            blank_mask  <= 3'b000;
            edit_mode   <= 1'b0;
        end else begin
            state       <= state_nx;
            edit_h      <= edit_h_nx;
            edit_m      <= edit_m_nx;
            edit_s      <= edit_s_nx;
            idle_cnt    <= idle_nx;
            blink_phase <= blink_nx;
            run_en      <= run_en_nx;
            load        <= load_nx;
            load_time   <= load_time_nx;
            blank_mask  <= blank_nx;
            edit_mode   <= edit_mode_nx;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [23:0] cur_time = 24'd0;
    logic        run_en;
    logic        load;
    logic [23:0] load_time;
    logic [2:0]  blank_mask;
    logic        edit_mode;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .HOUR(5), .MINUTE(3), .SECOND(21), .TIMEOUT(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .cur_time(cur_time),
        .run_en(run_en),
        .load(load),
        .load_time(load_time),
        .blank_mask(blank_mask),
        .edit_mode(edit_mode)
    );

    typedef struct packed {
        logic        r;
        logic        t;
        logic        m;
        logic        i;
        logic [23:0] ct;
        logic        e_run;
        logic        e_load;
        logic [23:0] e_lt;
        logic [2:0]  e_blank;
        logic        e_edit;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chk_all(input string name, input logic e_run, input logic e_load,
                           input logic [23:0] e_lt, input logic [2:0] e_blank,
                           input logic e_edit);
        chk({name, ".run_en"}, {23'd0, run_en}, {23'd0, e_run});
        chk({name, ".load"}, {23'd0, load}, {23'd0, e_load});
        chk({name, ".load_time"}, load_time, e_lt);
        chk({name, ".blank_mask"}, {21'd0, blank_mask}, {21'd0, e_blank});
        chk({name, ".edit_mode"}, {23'd0, edit_mode}, {23'd0, e_edit});
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic t, input logic m, input logic i,
                        input logic [23:0] ct);
        @(negedge clk);
        rst = r; tick = t; btn_mode = m; btn_inc = i; cur_time = ct;
        @(posedge clk);
        #1;
    endtask

    localparam logic [23:0] CA = 24'h020107;  // {2,1,7}
    localparam logic [23:0] CW = 24'h030214;  // {3,2,20}
    localparam logic [23:0] CS = 24'h010203;  // {1,2,3}
    localparam logic [23:0] CO = 24'h070109;  // {7,1,9}, hour out of range

    initial begin
        logic [23:0] ct;

        //         r  t  m  i  ct   run ld lt           blank  edit
        vecs.push_back('{1, 0, 0, 0, CA, 1, 0, 24'h000000, 3'b000, 0});
        vecs.push_back('{1, 0, 0, 0, CA, 1, 0, 24'h000000, 3'b000, 0});
        vecs.push_back('{0, 0, 0, 0, CA, 1, 0, 24'h000000, 3'b000, 0});
        vecs.push_back('{0, 0, 1, 0, CA, 0, 0, 24'h000000, 3'b000, 1});  // SET_H
        vecs.push_back('{0, 0, 0, 1, CA, 0, 0, 24'h000000, 3'b000, 1});  // h=3
        vecs.push_back('{0, 0, 0, 1, CA, 0, 0, 24'h000000, 3'b000, 1});  // h=4
        vecs.push_back('{0, 0, 1, 0, CA, 0, 0, 24'h000000, 3'b000, 1});  // SET_M
        vecs.push_back('{0, 0, 0, 1, CA, 0, 0, 24'h000000, 3'b000, 1});  // m=2
        vecs.push_back('{0, 0, 1, 0, CA, 0, 0, 24'h000000, 3'b000, 1});  // SET_S
        vecs.push_back('{0, 0, 1, 0, CA, 0, 1, 24'h040207, 3'b000, 0});  // commit
        vecs.push_back('{0, 0, 0, 0, CA, 1, 0, 24'h040207, 3'b000, 0});
        vecs.push_back('{0, 1, 0, 0, CA, 1, 0, 24'h040207, 3'b000, 0});  // tick in RUN
        vecs.push_back('{0, 0, 0, 1, CA, 1, 0, 24'h040207, 3'b000, 0});  // inc in RUN
        vecs.push_back('{0, 0, 1, 0, CA, 0, 0, 24'h040207, 3'b000, 1});  // SET_H
        vecs.push_back('{0, 1, 0, 0, CA, 0, 0, 24'h040207, 3'b100, 1});  // blink
        vecs.push_back('{0, 1, 0, 0, CA, 0, 0, 24'h040207, 3'b000, 1});
        vecs.push_back('{0, 1, 0, 0, CA, 0, 0, 24'h040207, 3'b100, 1});
        vecs.push_back('{0, 0, 0, 0, CA, 0, 0, 24'h040207, 3'b100, 1});
        vecs.push_back('{1, 0, 0, 0, CA, 1, 0, 24'h000000, 3'b000, 0});  // rst
        vecs.push_back('{0, 0, 1, 0, CW, 0, 0, 24'h000000, 3'b000, 1});  // SET_H
        vecs.push_back('{0, 0, 1, 0, CW, 0, 0, 24'h000000, 3'b000, 1});  // SET_M
        vecs.push_back('{0, 0, 0, 1, CW, 0, 0, 24'h000000, 3'b000, 1});  // m 2->0
        vecs.push_back('{0, 0, 1, 0, CW, 0, 0, 24'h000000, 3'b000, 1});  // SET_S
        vecs.push_back('{0, 0, 0, 1, CW, 0, 0, 24'h000000, 3'b000, 1});  // s 20->0
        vecs.push_back('{0, 0, 1, 0, CW, 0, 1, 24'h030000, 3'b000, 0});  // commit
        vecs.push_back('{0, 0, 0, 0, CW, 1, 0, 24'h030000, 3'b000, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].m, vecs[i].i, vecs[i].ct);
            chk_all($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_load,
                    vecs[i].e_lt, vecs[i].e_blank, vecs[i].e_edit);
        end

        // Timeout: 10 idle ticks in SET_H abort back to RUN without a load.
        ct = CA;
        step(0, 0, 1, 0, ct);
        for (int k = 1; k <= 9; k++) begin
            step(0, 1, 0, 0, ct);
            chk($sformatf("to_tick%0d.edit_mode", k), {23'd0, edit_mode}, 24'd1);
        end
        step(0, 1, 0, 0, ct);
        chk_all("to_expire", 1, 0, 24'h030000, 3'b000, 0);
        step(0, 0, 0, 0, ct);
        chk_all("to_after", 1, 0, 24'h030000, 3'b000, 0);

        // btn_inc at tick 9 restarts the idle count.
        step(0, 0, 1, 0, ct);
        for (int k = 1; k <= 8; k++) step(0, 1, 0, 0, ct);
        step(0, 1, 0, 1, ct);
        step(0, 1, 0, 0, ct);
        chk("to_inc9.edit_mode", {23'd0, edit_mode}, 24'd1);
        chk("to_inc9.run_en", {23'd0, run_en}, 24'd0);
        // Button on the expiring tick itself wins.
        for (int k = 1; k <= 8; k++) step(0, 1, 0, 0, ct);
        step(0, 1, 0, 1, ct);
        chk("to_prio.edit_mode", {23'd0, edit_mode}, 24'd1);
        step(0, 1, 0, 0, ct);
        chk("to_prio2.edit_mode", {23'd0, edit_mode}, 24'd1);
        step(1, 0, 0, 0, ct);
        chk_all("to_rst", 1, 0, 24'h000000, 3'b000, 0);

        // Simultaneous mode+inc in SET_H, then blink in SET_M.
        ct = CS;
        step(0, 0, 1, 0, ct);
        step(0, 0, 1, 1, ct);
        chk_all("sim", 0, 0, 24'h000000, 3'b000, 1);
        step(0, 1, 0, 0, ct);
        chk("blink1", {21'd0, blank_mask}, {21'd0, 3'b010});
        step(0, 1, 0, 0, ct);
        chk("blink2", {21'd0, blank_mask}, {21'd0, 3'b000});
        step(0, 1, 0, 0, ct);
        chk("blink3", {21'd0, blank_mask}, {21'd0, 3'b010});
        step(0, 0, 1, 0, ct);
        chk_all("sim_set_s", 0, 0, 24'h000000, 3'b000, 1);
        step(0, 0, 1, 0, ct);
        chk_all("sim_commit", 0, 1, 24'h010203, 3'b000, 0);
        step(0, 0, 0, 0, ct);
        chk_all("sim_run", 1, 0, 24'h010203, 3'b000, 0);

        // Reset in SET_S, even with btn_mode present, gives no load.
        step(0, 0, 1, 0, ct);
        step(0, 0, 1, 0, ct);
        step(0, 0, 1, 0, ct);
        step(1, 0, 1, 0, ct);
        chk_all("rst_mid", 1, 0, 24'h000000, 3'b000, 0);
        step(0, 0, 0, 0, ct);
        chk_all("rst_mid2", 1, 0, 24'h000000, 3'b000, 0);

        // Out-of-range hour captured as 0.
        ct = CO;
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, ct);
        chk_all("oor", 0, 1, 24'h000109, 3'b000, 0);
        step(0, 0, 0, 0, ct);
        chk_all("oor_run", 1, 0, 24'h000109, 3'b000, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
